// File: rtl/pdp_mem_arbiter_pkg.sv
// pdp_arb_pkg: shared types for the PDP-8 main-memory arbiter.
//   arb_state_e : arbiter FSM states
//   arb_grant_e : which requester owns the current / last transaction
//   LAT_CNT_W   : width of the read-latency counter (RD_LATENCY up to 7)
// Address/data widths come from the codebase-wide `ADDR_WIDTH / `DATA_WIDTH
// defines; the fallbacks below only apply when the slice is built standalone.
`ifndef ADDR_WIDTH
`define ADDR_WIDTH 12
`endif
`ifndef DATA_WIDTH
`define DATA_WIDTH 12
`endif

package pdp_arb_pkg;
  typedef enum logic [1:0] {IDLE, RD_ISSUE, RD_WAIT, WR_ISSUE} arb_state_e;
  typedef enum logic {GNT_IFU, GNT_EXU} arb_grant_e;
  localparam int unsigned LAT_CNT_W = 3;
endpackage

// File: rtl/pdp_mem_arbiter_if.sv
// pdp_mem_arbiter_if: memory-side bus between the arbiter and the single-port
// main memory.
//   mem_rd_req  : one-cycle read strobe            (arbiter -> memory)
//   mem_wr_req  : one-cycle write strobe           (arbiter -> memory)
//   mem_addr    : memory address                   (arbiter -> memory)
//   mem_wr_data : write data                       (arbiter -> memory)
//   mem_rd_data : read data, RD_LATENCY after strobe (memory -> arbiter)
`ifndef ADDR_WIDTH
`define ADDR_WIDTH 12
`endif
`ifndef DATA_WIDTH
`define DATA_WIDTH 12
`endif

interface pdp_mem_arbiter_if;
  logic                   mem_rd_req;
  logic                   mem_wr_req;
  logic [`ADDR_WIDTH-1:0] mem_addr;
  logic [`DATA_WIDTH-1:0] mem_wr_data;
  logic [`DATA_WIDTH-1:0] mem_rd_data;

  modport master (
    output mem_rd_req, mem_wr_req, mem_addr, mem_wr_data,
    input  mem_rd_data
  );

  modport slave (
    input  mem_rd_req, mem_wr_req, mem_addr, mem_wr_data,
    output mem_rd_data
  );
endinterface

// File: rtl/pdp_mem_arbiter.sv
// pdp_mem_arbiter: shares the single-port PDP-8 main memory between the IFU
// (read-only) and the EXU (read/write). One transaction at a time, round-robin
// on contention, requests sampled only in IDLE.
// Ports:
//   clk, reset          : clock, synchronous active-high reset
//   ifu_rd_req/addr     : IFU read request (level) and address
//   ifu_rd_data/valid   : IFU read data (= mem_rd_data) and one-cycle valid
//   exu_rd_req/wr_req   : EXU read / write requests (level)
//   exu_addr/wr_data    : EXU address and write data
//   exu_rd_data/valid   : EXU read data (= mem_rd_data) and one-cycle valid
//   exu_wr_ack          : one-cycle pulse, write performed
//   mem                 : memory bus (master side)
//   busy                : transaction in flight
//   proto_err           : sticky, EXU asserted rd and wr together
// RD_LATENCY must lie in 1..7.
`ifndef ADDR_WIDTH
`define ADDR_WIDTH 12
`endif
`ifndef DATA_WIDTH
`define DATA_WIDTH 12
`endif

module pdp_mem_arbiter
  import pdp_arb_pkg::*;
#(
  parameter int unsigned RD_LATENCY = 1
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   ifu_rd_req,
  input  logic [`ADDR_WIDTH-1:0] ifu_rd_addr,
  output logic [`DATA_WIDTH-1:0] ifu_rd_data,
  output logic                   ifu_rd_valid,
  input  logic                   exu_rd_req,
  input  logic                   exu_wr_req,
  input  logic [`ADDR_WIDTH-1:0] exu_addr,
  input  logic [`DATA_WIDTH-1:0] exu_wr_data,
  output logic [`DATA_WIDTH-1:0] exu_rd_data,
  output logic                   exu_rd_valid,
  output logic                   exu_wr_ack,
  pdp_mem_arbiter_if.master      mem,
  output logic                   busy,
  output logic                   proto_err
);

  arb_state_e           state;
  arb_grant_e           last_grant;
  logic [LAT_CNT_W-1:0] lat_cnt;
  logic                 exu_req;
  logic                 grant_ifu;
  logic                 rd_done;

  always_comb begin
    exu_req   = exu_rd_req | exu_wr_req;
    // IFU wins when alone, or on a tie when the EXU had the previous grant.
    grant_ifu = ifu_rd_req & (~exu_req | (last_grant == GNT_EXU));
    rd_done   = (lat_cnt == LAT_CNT_W'(1));
  end

  assign ifu_rd_data = mem.mem_rd_data;
  assign exu_rd_data = mem.mem_rd_data;

  always_ff @(posedge clk) begin
    if (reset) begin
      state           <= IDLE;
      last_grant      <= GNT_EXU;
      lat_cnt         <= '0;
      mem.mem_rd_req  <= 1'b0;
      mem.mem_wr_req  <= 1'b0;
      mem.mem_addr    <= '0;
      mem.mem_wr_data <= '0;
      ifu_rd_valid    <= 1'b0;
      exu_rd_valid    <= 1'b0;
      exu_wr_ack      <= 1'b0;
      busy            <= 1'b0;
      proto_err       <= 1'b0;
    end else begin
      mem.mem_rd_req <= 1'b0;
      mem.mem_wr_req <= 1'b0;
      ifu_rd_valid   <= 1'b0;
      exu_rd_valid   <= 1'b0;
      exu_wr_ack     <= 1'b0;
      unique case (state)
        IDLE: begin
          if (grant_ifu) begin
            state          <= RD_ISSUE;
            last_grant     <= GNT_IFU;
            mem.mem_rd_req <= 1'b1;
            mem.mem_addr   <= ifu_rd_addr;
            lat_cnt        <= LAT_CNT_W'(RD_LATENCY);
            busy           <= 1'b1;
          end else if (exu_req) begin
            last_grant   <= GNT_EXU;
            mem.mem_addr <= exu_addr;
            busy         <= 1'b1;
            if (exu_wr_req) begin
              // rd+wr together is executed as a write and flagged.
              state           <= WR_ISSUE;
              mem.mem_wr_req  <= 1'b1;
              mem.mem_wr_data <= exu_wr_data;
              exu_wr_ack      <= 1'b1;
              proto_err       <= proto_err | exu_rd_req;
            end else begin
              state          <= RD_ISSUE;
              mem.mem_rd_req <= 1'b1;
              lat_cnt        <= LAT_CNT_W'(RD_LATENCY);
            end
          end
        end
        // Counter is loaded with RD_LATENCY in RD_ISSUE and counts down once
        // per cycle; the valid pulse is launched when it passes 1 so it lands
        // in the same cycle the memory presents its data. The cycle after the
        // pulse closes the transaction.
        RD_ISSUE, RD_WAIT: begin
          if (ifu_rd_valid | exu_rd_valid) begin
            state <= IDLE;
            busy  <= 1'b0;
          end else begin
            state   <= RD_WAIT;
            lat_cnt <= lat_cnt - 1'b1;
            if (rd_done) begin
              ifu_rd_valid <= (last_grant == GNT_IFU);
              exu_rd_valid <= (last_grant == GNT_EXU);
            end
          end
        end
        WR_ISSUE: begin
          state <= IDLE;
          busy  <= 1'b0;
        end
        default: begin
          state <= IDLE;
          busy  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_pdp_mem_arbiter.sv
module tb_pdp_mem_arbiter;
  import pdp_arb_pkg::*;

  localparam int AW  = `ADDR_WIDTH;
  localparam int DW  = `DATA_WIDTH;
  localparam int LAT = 2;
  localparam int SW_LAT [2] = '{1, 7};

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_chk = 0;
  int n_err = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s @cyc %0d: got 'o%0o, want 'o%0o", tag, cyc, obs, exp);
    end
  endtask

  function automatic logic [DW-1:0] init_val(input int a);
    return DW'((a * 1427 + 291) & ((1 << DW) - 1));
  endfunction

  // ---------------- main DUT (RD_LATENCY = 2) ----------------
  logic          reset;
  logic          ifu_rd_req, ifu_rd_valid;
  logic [AW-1:0] ifu_rd_addr;
  logic [DW-1:0] ifu_rd_data;
  logic          exu_rd_req, exu_wr_req, exu_rd_valid, exu_wr_ack;
  logic [AW-1:0] exu_addr;
  logic [DW-1:0] exu_wr_data, exu_rd_data;
  logic          busy, proto_err;

  pdp_mem_arbiter_if mif();

  pdp_mem_arbiter #(.RD_LATENCY(LAT)) u_dut (
    .clk(clk), .reset(reset),
    .ifu_rd_req(ifu_rd_req), .ifu_rd_addr(ifu_rd_addr),
    .ifu_rd_data(ifu_rd_data), .ifu_rd_valid(ifu_rd_valid),
    .exu_rd_req(exu_rd_req), .exu_wr_req(exu_wr_req),
    .exu_addr(exu_addr), .exu_wr_data(exu_wr_data),
    .exu_rd_data(exu_rd_data), .exu_rd_valid(exu_rd_valid),
    .exu_wr_ack(exu_wr_ack), .mem(mif.master),
    .busy(busy), .proto_err(proto_err)
  );

  // memory environment: array written only by the main process
  logic [DW-1:0] mem     [0:(1<<AW)-1];
  logic [DW-1:0] ref_mem [0:(1<<AW)-1];
  logic [DW-1:0] pend_data = '0;
  int            pend_cyc  = -100;

  always @(posedge clk) begin
    if (mif.mem_rd_req === 1'b1) begin
      pend_data <= mem[mif.mem_addr];
      pend_cyc  <= cyc + LAT;
    end
  end
  assign mif.mem_rd_data = (cyc == pend_cyc) ? pend_data : ~pend_data;

  // ---------------- transaction-level reference model ----------------
  int            m_issue, m_resp, m_end;
  bit            m_is_wr, m_to_ifu, m_last_exu, m_perr;
  logic [AW-1:0] m_addr;
  logic [DW-1:0] m_wdata, m_rdata;

  task automatic model_reset();
    m_issue = -1; m_resp = -1; m_end = -1;
    m_last_exu = 1'b1; m_perr = 1'b0;
  endtask

  // called with this cycle's inputs; the arbiter only looks when idle
  task automatic model_sample();
    bit e;
    e = exu_rd_req | exu_wr_req;
    if (cyc > m_end && (ifu_rd_req || e)) begin
      m_to_ifu   = ifu_rd_req && (!e || m_last_exu);
      m_last_exu = !m_to_ifu;
      m_is_wr    = !m_to_ifu && exu_wr_req;
      if (!m_to_ifu && exu_wr_req && exu_rd_req) m_perr = 1'b1;
      m_addr  = m_to_ifu ? ifu_rd_addr : exu_addr;
      m_issue = cyc + 1;
      if (m_is_wr) begin
        m_wdata = exu_wr_data;
        ref_mem[m_addr] = m_wdata;
        m_resp = cyc + 1;
      end else begin
        m_rdata = ref_mem[m_addr];
        m_resp  = cyc + 1 + LAT;
      end
      m_end = m_resp;
    end
  endtask

  task automatic check_outputs();
    bool_chk: begin
      check("busy", busy, cyc >= m_issue && cyc <= m_end);
      check("mem_rd_req", mif.mem_rd_req, cyc == m_issue && !m_is_wr);
      check("mem_wr_req", mif.mem_wr_req, cyc == m_issue && m_is_wr);
      check("ifu_rd_valid", ifu_rd_valid, cyc == m_resp && m_to_ifu);
      check("exu_rd_valid", exu_rd_valid, cyc == m_resp && !m_to_ifu && !m_is_wr);
      check("exu_wr_ack", exu_wr_ack, cyc == m_resp && m_is_wr);
      check("proto_err", proto_err, m_perr);
    end
    if (cyc == m_issue) begin
      check("mem_addr", mif.mem_addr, m_addr);
      if (m_is_wr) check("mem_wr_data", mif.mem_wr_data, m_wdata);
    end
    if (cyc == m_resp && !m_is_wr) begin
      if (m_to_ifu) check("ifu_rd_data", ifu_rd_data, m_rdata);
      else          check("exu_rd_data", exu_rd_data, m_rdata);
    end
  endtask

  task automatic next_cycle();
    @(posedge clk);
    #1;
    check_outputs();
    if (mif.mem_wr_req === 1'b1) mem[mif.mem_addr] = mif.mem_wr_data;
  endtask

  task automatic commit();
    if (reset) model_reset();
    else       model_sample();
  endtask

  task automatic clear_inputs();
    ifu_rd_req = 1'b0; ifu_rd_addr = '0;
    exu_rd_req = 1'b0; exu_wr_req = 1'b0; exu_addr = '0; exu_wr_data = '0;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    clear_inputs();
    commit();
    next_cycle();
    commit();
    next_cycle();
    reset = 1'b0;
  endtask

  function automatic logic [AW-1:0] rand_addr();
    return AW'(12'o100 + $urandom_range(15, 0));
  endfunction

  task automatic drive_random();
    int unsigned r;
    if (reset) reset = 1'b0;
    else if ($urandom_range(999, 0) < 3) reset = 1'b1;
    if (ifu_rd_req) begin
      if (ifu_rd_valid) begin
        ifu_rd_req = 1'($urandom_range(1, 0));
        ifu_rd_addr = rand_addr();
      end else if ($urandom_range(99, 0) < 3) ifu_rd_req = 1'b0;
    end else if ($urandom_range(99, 0) < 40) begin
      ifu_rd_req = 1'b1; ifu_rd_addr = rand_addr();
    end
    if (exu_rd_req || exu_wr_req) begin
      if (exu_rd_valid || exu_wr_ack || $urandom_range(99, 0) < 3) begin
        exu_rd_req = 1'b0; exu_wr_req = 1'b0;
      end
    end else if ($urandom_range(99, 0) < 40) begin
      r = $urandom_range(99, 0);
      exu_rd_req  = (r < 45) || (r >= 95);
      exu_wr_req  = (r >= 45);
      exu_addr    = rand_addr();
      exu_wr_data = DW'($urandom);
    end
  endtask

  // ---------------- latency sweep DUTs (continuous IFU reads) ----------------
  logic sw_reset = 1'b1;
  logic sw_en    = 1'b0;
  bit   sw_done  = 1'b0;
  int   sw_start = 0;

  for (genvar g = 0; g < 2; g++) begin : g_sweep
    localparam int L = SW_LAT[g];
    pdp_mem_arbiter_if sif();
    logic [AW-1:0] addr = AW'(12'o100);
    logic [DW-1:0] rdata, erdata, pdata = '0;
    logic          valid, evalid, eack, sbusy, sperr;
    int            pcyc = -100;
    int            nvalid = 0;

    pdp_mem_arbiter #(.RD_LATENCY(L)) u_dut (
      .clk(clk), .reset(sw_reset),
      .ifu_rd_req(sw_en), .ifu_rd_addr(addr),
      .ifu_rd_data(rdata), .ifu_rd_valid(valid),
      .exu_rd_req(1'b0), .exu_wr_req(1'b0),
      .exu_addr('0), .exu_wr_data('0),
      .exu_rd_data(erdata), .exu_rd_valid(evalid),
      .exu_wr_ack(eack), .mem(sif.master),
      .busy(sbusy), .proto_err(sperr)
    );

    always @(posedge clk) begin
      if (sif.mem_rd_req === 1'b1) begin
        pdata <= init_val(int'(sif.mem_addr));
        pcyc  <= cyc + L;
      end
    end
    assign sif.mem_rd_data = (cyc == pcyc) ? pdata : ~pdata;

    always @(posedge clk) begin
      int  p;
      bit  exp_v;
      #1;
      if (sw_en && !sw_done && cyc > sw_start) begin
        p     = (cyc - sw_start - 1) % (L + 2);
        exp_v = (p == L);
        check($sformatf("sweep%0d_valid", L), valid, exp_v);
        check($sformatf("sweep%0d_busy", L), sbusy, p != L + 1);
        check($sformatf("sweep%0d_quiet", L), {evalid, eack, sperr, sif.mem_wr_req}, 0);
        if (exp_v && valid) begin
          check($sformatf("sweep%0d_data", L), rdata, init_val(int'(addr)));
          check($sformatf("sweep%0d_exu_data", L), erdata, init_val(int'(addr)));
          nvalid++;
          addr = addr + 1'b1;
        end
      end
    end
  end

  // ---------------- main sequence ----------------
  initial begin
    for (int i = 0; i < (1 << AW); i++) begin
      mem[i] = init_val(i);
      ref_mem[i] = init_val(i);
    end
    model_reset();
    do_reset();
    check("rst_outputs", {busy, proto_err, mif.mem_rd_req, mif.mem_wr_req,
                          ifu_rd_valid, exu_rd_valid, exu_wr_ack}, 0);
    check("rst_mem_addr", mif.mem_addr, 0);
    check("rst_mem_wr_data", mif.mem_wr_data, 0);

    sw_start = cyc;
    sw_reset = 1'b0;
    sw_en    = 1'b1;

    // single IFU read, latency 2
    mem[12'o200] = 12'o7001; ref_mem[12'o200] = 12'o7001;
    ifu_rd_req = 1'b1; ifu_rd_addr = 12'o200;
    commit();
    for (int k = 1; k <= 4; k++) begin
      next_cycle();
      if (k == 1) begin
        check("t1_rd_req", mif.mem_rd_req, 1);
        check("t1_addr", mif.mem_addr, 12'o200);
      end
      if (k == 3) begin
        check("t1_valid", ifu_rd_valid, 1);
        check("t1_data", ifu_rd_data, 12'o7001);
        ifu_rd_req = 1'b0;
      end
      if (k == 4) check("t1_idle", busy, 0);
      commit();
    end

    // tie after reset: IFU, then EXU, then IFU again
    do_reset();
    ifu_rd_req = 1'b1; ifu_rd_addr = 12'o300;
    exu_rd_req = 1'b1; exu_addr = 12'o400;
    commit();
    for (int k = 1; k <= 9; k++) begin
      next_cycle();
      if (k == 1) check("t2_first_ifu", mif.mem_addr, 12'o300);
      if (k == 3) begin
        check("t2_ifu_valid", ifu_rd_valid, 1);
        ifu_rd_req = 1'b0;
      end
      if (k == 5) begin
        check("t2_exu_rd_req", mif.mem_rd_req, 1);
        check("t2_exu_addr", mif.mem_addr, 12'o400);
      end
      if (k == 7) begin
        check("t2_exu_valid", exu_rd_valid, 1);
        exu_rd_req = 1'b0;
      end
      if (k == 8) begin
        ifu_rd_req = 1'b1; ifu_rd_addr = 12'o301;
        exu_rd_req = 1'b1; exu_addr = 12'o401;
      end
      if (k == 9) begin
        check("t2_alt_ifu", mif.mem_addr, 12'o301);
        ifu_rd_req = 1'b0; exu_rd_req = 1'b0;
      end
      commit();
    end

    // EXU write
    do_reset();
    exu_wr_req = 1'b1; exu_addr = 12'o050; exu_wr_data = 12'o1234;
    commit();
    next_cycle();
    check("t3_wr", {mif.mem_wr_req, exu_wr_ack, mif.mem_rd_req}, 3'b110);
    check("t3_addr", mif.mem_addr, 12'o050);
    check("t3_data", mif.mem_wr_data, 12'o1234);
    exu_wr_req = 1'b0;
    commit();
    next_cycle();
    check("t3_idle", busy, 0);
    commit();

    // EXU rd+wr together
    exu_rd_req = 1'b1; exu_wr_req = 1'b1; exu_addr = 12'o060; exu_wr_data = 12'o4321;
    commit();
    for (int k = 1; k <= 5; k++) begin
      next_cycle();
      if (k == 1) check("t4_wr_not_rd", {mif.mem_wr_req, mif.mem_rd_req}, 2'b10);
      check($sformatf("t4_perr_k%0d", k), proto_err, 1);
      exu_rd_req = 1'b0; exu_wr_req = 1'b0;
      commit();
    end
    do_reset();
    check("t4_perr_cleared", proto_err, 0);

    // reset during RD_WAIT
    ifu_rd_req = 1'b1; ifu_rd_addr = 12'o200;
    commit();
    next_cycle(); commit();
    next_cycle();
    reset = 1'b1; ifu_rd_req = 1'b0;
    commit();
    next_cycle();
    check("t5_no_valid", {ifu_rd_valid, busy, mif.mem_rd_req}, 0);
    check("t5_addr_zero", mif.mem_addr, 0);
    reset = 1'b0;
    ifu_rd_req = 1'b1; ifu_rd_addr = 12'o210;
    exu_rd_req = 1'b1; exu_addr = 12'o410;
    commit();
    next_cycle();
    check("t5_tie_ifu", mif.mem_addr, 12'o210);
    clear_inputs();
    commit();

    // randomized traffic
    for (int n = 0; n < 3000; n++) begin
      next_cycle();
      drive_random();
      commit();
    end

    sw_done = 1'b1;
    check("sweep1_count", g_sweep[0].nvalid > 20, 1);
    check("sweep7_count", g_sweep[1].nvalid > 20, 1);
    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end

endmodule
